display_fb_writer: RTL

//  Write side of the 8x8 bi-colour frame RAM that the LED scanner reads.

---
 rtl/display_pkg.sv | 38 +++
 rtl/display_fb_writer_if.sv | 29 ++
 rtl/display_fb_sweep_gen.sv | 73 +++++++
 rtl/display_fb_writer.sv | 96 +++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the 8x8 bi-colour display: frame geometry, drawing opcodes, colours.
package display_pkg;

  localparam int unsigned FB_ADDR_W  = 6;
  localparam int unsigned FB_COLOR_W = 2;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_SET   = 3'd1;
  localparam logic [2:0] OP_ROW   = 3'd2;
  localparam logic [2:0] OP_COL   = 3'd3;
  localparam logic [2:0] OP_FILL  = 3'd4;
  localparam logic [2:0] OP_CLEAR = 3'd5;

  localparam logic [1:0] C_OFF    = 2'b00;
  localparam logic [1:0] C_GREEN  = 2'b01;
  localparam logic [1:0] C_RED    = 2'b10;
  localparam logic [1:0] C_YELLOW = 2'b11;

  typedef enum logic [1:0] {SwSingle, SwRow, SwCol, SwFull} sweep_mode_e;

  typedef enum logic [1:0] {StIdle, StWrite, StFin} fb_state_e;

  function automatic logic op_is_write(input logic [2:0] op);
    return (op >= OP_SET) && (op <= OP_CLEAR);
  endfunction

  function automatic sweep_mode_e op_to_mode(input logic [2:0] op);
    sweep_mode_e mode;
    case (op)
      OP_ROW:            mode = SwRow;
      OP_COL:            mode = SwCol;
      OP_FILL, OP_CLEAR: mode = SwFull;
      default:           mode = SwSingle;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/display_fb_writer_if.sv
// Drawing-command handshake between control logic (master) and the frame writer (slave).
interface display_fb_writer_if #(
  parameter int unsigned ADDR_W  = display_pkg::FB_ADDR_W,
  parameter int unsigned COLOR_W = display_pkg::FB_COLOR_W
);

  logic               cmd_valid;
  logic               cmd_ready;
  logic [2:0]         cmd_op;
  logic [ADDR_W-1:0]  cmd_pos;
  logic [COLOR_W-1:0] cmd_color;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_pos,
    output cmd_color,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_pos,
    input  cmd_color,
    output cmd_ready
  );

endinterface

// File: rtl/display_fb_sweep_gen.sv
// Pixel sweep for one burst: index counter, row/col/full address mux and last-index flag.
module display_fb_sweep_gen
  import display_pkg::*;
(
  input  logic                 scan_clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 step,
  input  sweep_mode_e          mode,
  input  logic [FB_ADDR_W-1:0] pos,
  output logic                 last,
  output logic [FB_ADDR_W-1:0] nxt_addr,
  output logic                 nxt_last
);

  logic [5:0]           cnt_q, cnt_d;
  sweep_mode_e          mode_q, mode_d;
  logic [FB_ADDR_W-1:0] pos_q, pos_d;

  function automatic logic is_last(input sweep_mode_e m, input logic [5:0] idx);
    logic res;
    case (m)
      SwRow, SwCol: res = (idx[2:0] == 3'd7);
      SwFull:       res = (idx == 6'd63);
      default:      res = 1'b1;
    endcase
    return res;
  endfunction

  function automatic logic [FB_ADDR_W-1:0] sweep_addr(input sweep_mode_e m,
                                                      input logic [FB_ADDR_W-1:0] p,
                                                      input logic [5:0] idx);
    logic [FB_ADDR_W-1:0] res;
    case (m)
      SwRow:   res = {p[5:3], idx[2:0]};
      SwCol:   res = {idx[2:0], p[2:0]};
      SwFull:  res = idx;
      default: res = p;
    endcase
    return res;
  endfunction

  always_comb begin
    cnt_d  = cnt_q;
    mode_d = mode_q;
    pos_d  = pos_q;
    if (start) begin
      cnt_d  = '0;
      mode_d = mode;
      pos_d  = pos;
    end else if (step) begin
      cnt_d = cnt_q + 6'd1;
    end
  end

  // Address and last flag are looked up on the next index so the writer can register them.
  assign last     = is_last(mode_q, cnt_q);
  assign nxt_last = is_last(mode_d, cnt_d);
  assign nxt_addr = sweep_addr(mode_d, pos_d, cnt_d);

  always_ff @(posedge scan_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      mode_q <= SwSingle;
      pos_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      pos_q  <= pos_d;
    end
  end

endmodule

// File: rtl/display_fb_writer.sv
// Frame RAM write side: turns drawing commands into bursts of single-pixel writes.
module display_fb_writer
  import display_pkg::*;
#(
  parameter int unsigned ADDR_W  = FB_ADDR_W,
  parameter int unsigned COLOR_W = FB_COLOR_W
) (
  input  logic                scan_clk,
  input  logic                rst_n,
  display_fb_writer_if.slave  cmd,
  output logic                ram_wr_en,
  output logic [ADDR_W-1:0]   ram_wr_addr,
  output logic [COLOR_W-1:0]  ram_wr_data,
  output logic                busy,
  output logic                done
);

  fb_state_e            state_q, state_d;
  logic [COLOR_W-1:0]   color_q, color_d;
  logic                 accept, start, step;
  logic                 last, nxt_last;
  logic [FB_ADDR_W-1:0] nxt_addr;
  logic                 wr_en_d, done_d, busy_d;
  logic [ADDR_W-1:0]    addr_d;
  logic [COLOR_W-1:0]   data_d;

  assign cmd.cmd_ready = (state_q == StIdle);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  display_fb_sweep_gen u_sweep (
    .scan_clk (scan_clk),
    .rst_n    (rst_n),
    .start    (start),
    .step     (step),
    .mode     (op_to_mode(cmd.cmd_op)),
    .pos      (cmd.cmd_pos),
    .last     (last),
    .nxt_addr (nxt_addr),
    .nxt_last (nxt_last)
  );

  always_ff @(posedge scan_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      color_q     <= '0;
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      color_q     <= color_d;
      ram_wr_en   <= wr_en_d;
      ram_wr_addr <= addr_d;
      ram_wr_data <= data_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    color_d = color_q;
    start   = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          start   = 1'b1;
          color_d = (cmd.cmd_op == OP_CLEAR) ? C_OFF : cmd.cmd_color;
          state_d = op_is_write(cmd.cmd_op) ? StWrite : StFin;
        end
      end
      StWrite: begin
        if (last) begin
          state_d = StIdle;
        end else begin
          step = 1'b1;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from next-state values so the first write lands right after accept.
  always_comb begin
    wr_en_d = (state_d == StWrite);
    done_d  = (state_d == StFin) || (wr_en_d && nxt_last);
    busy_d  = (state_d != StIdle);
    addr_d  = wr_en_d ? nxt_addr : ram_wr_addr;
    data_d  = wr_en_d ? color_d : ram_wr_data;
  end

endmodule
